// File: rtl/wb_commit_pkg.sv
// Shared types and constants for the writeback/commit stage.
package wb_commit_pkg;

  localparam logic [31:0] TRAP_INST_DEFAULT = 32'h0010_0073;

  localparam int unsigned ST_W = 2;
  typedef logic [ST_W-1:0] state_t;
  localparam state_t ST_RUN   = 2'd0;
  localparam state_t ST_DRAIN = 2'd1;
  localparam state_t ST_HALT  = 2'd2;

  // Commit-trace entry layout at the default XLEN=64 / ILEN=32
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        trap;
    logic [63:0] trap_code;
  } cm_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous-reset FIFO with full/empty/count; a pop while full makes room for a same-cycle push.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign count   = cnt;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/wb_commit_stage.sv
// Writeback register, commit-trace push, retire counter and trap drain/halt control.
module wb_commit_stage
  import wb_commit_pkg::*;
#(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned ILEN        = 32,
  parameter int unsigned RADDR_W     = 5,
  parameter int unsigned TRACE_DEPTH = 4,
  parameter logic [ILEN-1:0] TRAP_INST = ILEN'(TRAP_INST_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_pc,
  input  logic [ILEN-1:0]    in_inst,
  input  logic               in_rd_ena,
  input  logic [RADDR_W-1:0] in_rd_addr,
  input  logic [XLEN-1:0]    in_rd_data,
  input  logic [XLEN-1:0]    in_trap_code,
  input  logic               flush,
  output logic               wb_rd_ena,
  output logic [RADDR_W-1:0] wb_rd_addr,
  output logic [XLEN-1:0]    wb_rd_data,
  output logic               cm_valid,
  input  logic               cm_ready,
  output logic [XLEN-1:0]    cm_pc,
  output logic [ILEN-1:0]    cm_inst,
  output logic               cm_trap,
  output logic [XLEN-1:0]    cm_trap_code,
  output logic [63:0]        retired_cnt,
  output logic               halted
);

  localparam int unsigned ENTRY_W = 2*XLEN + ILEN + 1;
  localparam int unsigned CNT_W   = $clog2(TRACE_DEPTH) + 1;

  state_t             state_q, state_d;
  logic               accept, retire, is_trap;
  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [ENTRY_W-1:0] push_data, fifo_rdata;

  assign is_trap   = (in_inst == TRAP_INST);
  assign in_ready  = (state_q == ST_RUN) & ~flush & (~fifo_full | cm_ready);
  assign accept    = in_valid & in_ready;
  assign retire    = accept & (in_inst != '0);
  assign cm_valid  = ~fifo_empty;
  assign fifo_push = retire;
  assign fifo_pop  = cm_valid & cm_ready;
  assign push_data = {in_pc, in_inst, is_trap, is_trap ? in_trap_code : XLEN'(0)};
  assign {cm_pc, cm_inst, cm_trap, cm_trap_code} = fifo_rdata;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (push_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Halt as soon as the last trace entry (the trap) leaves the FIFO
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (retire & is_trap) state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty | ((fifo_count == CNT_W'(1)) & fifo_pop)) state_d = ST_HALT;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      halted  <= 1'b0;
    end else begin
      state_q <= state_d;
      halted  <= (state_d == ST_HALT);
    end
  end

  // Regfile write is a one-cycle pulse; x0 writes are suppressed
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wb_rd_ena  <= 1'b0;
      wb_rd_addr <= '0;
      wb_rd_data <= '0;
    end else if (retire) begin
      wb_rd_ena  <= in_rd_ena & (in_rd_addr != '0);
      wb_rd_addr <= in_rd_addr;
      wb_rd_data <= in_rd_data;
    end else begin
      wb_rd_ena  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         retired_cnt <= '0;
    else if (retire) retired_cnt <= retired_cnt + 64'd1;
  end

endmodule

// File: tb/tb_wb_commit_stage.sv
// Directed bench for wb_commit_stage with a trace scoreboard checked on every pop.
module tb_wb_commit_stage;
  import wb_commit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [63:0] in_pc;
  logic [31:0] in_inst;
  logic        in_rd_ena;
  logic [4:0]  in_rd_addr;
  logic [63:0] in_rd_data, in_trap_code;
  logic        flush;
  logic        wb_rd_ena;
  logic [4:0]  wb_rd_addr;
  logic [63:0] wb_rd_data;
  logic        cm_valid, cm_ready;
  logic [63:0] cm_pc;
  logic [31:0] cm_inst;
  logic        cm_trap;
  logic [63:0] cm_trap_code;
  logic [63:0] retired_cnt;
  logic        halted;

  int vectors = 0;
  int miscompares = 0;
  int pops = 0;
  logic [63:0] exp_cnt = 0;
  cm_entry_t exp_q[$];

  wb_commit_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .in_rd_ena(in_rd_ena),
    .in_rd_addr(in_rd_addr), .in_rd_data(in_rd_data), .in_trap_code(in_trap_code),
    .flush(flush), .wb_rd_ena(wb_rd_ena), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
    .cm_valid(cm_valid), .cm_ready(cm_ready), .cm_pc(cm_pc), .cm_inst(cm_inst),
    .cm_trap(cm_trap), .cm_trap_code(cm_trap_code), .retired_cnt(retired_cnt),
    .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for one edge and check ready/WB/count around it
  task automatic issue(input logic [63:0] pc, input logic [31:0] inst, input logic [4:0] rd,
                       input logic [63:0] data, input logic [63:0] code, input logic exp_rdy);
    cm_entry_t e;
    logic wr;
    in_valid = 1'b1; in_pc = pc; in_inst = inst; in_rd_ena = 1'b1;
    in_rd_addr = rd; in_rd_data = data; in_trap_code = code;
    #1 chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    wr = exp_rdy && (inst != 32'h0) && (rd != 5'd0);
    if (exp_rdy && inst != 32'h0) begin
      e.pc = pc; e.inst = inst;
      e.trap = (inst == 32'h0010_0073);
      e.trap_code = e.trap ? code : 64'h0;
      exp_q.push_back(e);
      exp_cnt++;
    end
    tick();
    chk("wb_rd_ena", 64'(wb_rd_ena), 64'(wr));
    if (wr) begin
      chk("wb_rd_addr", 64'(wb_rd_addr), 64'(rd));
      chk("wb_rd_data", wb_rd_data, data);
    end
    chk("retired_cnt", retired_cnt, exp_cnt);
  endtask

  // Every pop must match the oldest expected entry
  always @(negedge clk) begin
    if (!rst && cm_valid && cm_ready) begin
      chk("cm_q_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        cm_entry_t e;
        e = exp_q.pop_front();
        chk("cm_pc", cm_pc, e.pc);
        chk("cm_inst", 64'(cm_inst), 64'(e.inst));
        chk("cm_trap", 64'(cm_trap), 64'(e.trap));
        chk("cm_trap_code", cm_trap_code, e.trap_code);
        pops++;
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; cm_ready = 1'b0;
    in_pc = 0; in_inst = 0; in_rd_ena = 0; in_rd_addr = 0; in_rd_data = 0; in_trap_code = 0;
    tick(); tick();
    chk("rst_wb_rd_ena", 64'(wb_rd_ena), 64'd0);
    chk("rst_wb_rd_data", wb_rd_data, 64'd0);
    chk("rst_cm_valid", 64'(cm_valid), 64'd0);
    chk("rst_cm_pc", cm_pc, 64'd0);
    chk("rst_retired", retired_cnt, 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    rst = 1'b0;

    // Back-to-back stream, consumer always ready
    cm_ready = 1'b1;
    issue(64'h8000_0000, 32'h0000_0013, 5'd5, 64'd1, 64'd0, 1'b1);
    issue(64'h8000_0004, 32'h0000_0013, 5'd6, 64'd2, 64'd0, 1'b1);
    issue(64'h8000_0008, 32'h0000_0013, 5'd7, 64'd3, 64'd0, 1'b1);
    in_valid = 1'b0;
    tick();
    chk("wb_pulse_end", 64'(wb_rd_ena), 64'd0);
    chk("wb_data_hold", wb_rd_data, 64'd3);
    tick();
    chk("stream_pops", 64'(pops), 64'd3);
    chk("stream_retired", retired_cnt, 64'd3);

    // x0 destination still retires; a bubble does not
    issue(64'h8000_000c, 32'h0000_0013, 5'd0, 64'hdead, 64'd0, 1'b1);
    issue(64'h8000_0010, 32'h0000_0000, 5'd4, 64'hbeef, 64'd0, 1'b1);
    in_valid = 1'b0;
    tick();
    chk("x0_pops", 64'(pops), 64'd4);

    // Fill with consumer stalled, then push and pop together while full
    cm_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      issue(64'h8000_0020 + 64'(4*i), 32'h0000_0013, 5'(8 + i), 64'(16 + i), 64'd0, 1'b1);
    issue(64'h8000_0030, 32'h0000_0013, 5'd12, 64'd20, 64'd0, 1'b0);
    cm_ready = 1'b1;
    issue(64'h8000_0030, 32'h0000_0013, 5'd12, 64'd20, 64'd0, 1'b1);
    cm_ready = 1'b0; in_valid = 1'b0;
    #1 chk("still_full", 64'(in_ready), 64'd0);
    chk("full_pops", 64'(pops), 64'd5);
    cm_ready = 1'b1;
    repeat (5) tick();
    chk("drained", 64'(cm_valid), 64'd0);
    chk("drain_pops", 64'(pops), 64'd9);

    // Flush with a valid input: nothing accepted, WB cleared, trace kept
    cm_ready = 1'b0;
    issue(64'h8000_0040, 32'h0000_0013, 5'd9, 64'h99, 64'd0, 1'b1);
    flush = 1'b1;
    issue(64'h8000_0010, 32'h0000_0013, 5'd8, 64'h77, 64'd0, 1'b0);
    chk("flush_addr", 64'(wb_rd_addr), 64'd0);
    chk("flush_data", wb_rd_data, 64'd0);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_cm_valid", 64'(cm_valid), 64'd1);
    chk("flush_cm_pc", cm_pc, 64'h8000_0040);

    // Trap behind two pending entries
    issue(64'h8000_0044, 32'h0000_0013, 5'd10, 64'haa, 64'd0, 1'b1);
    issue(64'h8000_0048, 32'h0010_0073, 5'd0, 64'd0, 64'd0, 1'b1);
    in_inst = 32'h0000_0013;
    #1 chk("drain_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0; cm_ready = 1'b1;
    tick();
    chk("halt_early1", 64'(halted), 64'd0);
    tick();
    chk("halt_early2", 64'(halted), 64'd0);
    tick();
    chk("halted", 64'(halted), 64'd1);
    chk("halt_cm_valid", 64'(cm_valid), 64'd0);
    chk("halt_q_empty", 64'(exp_q.size()), 64'd0);
    repeat (3) tick();
    chk("halt_sticky", 64'(halted), 64'd1);
    in_valid = 1'b1;
    #1 chk("halt_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;

    // Reset recovers from HALT, then reset with two pending entries
    rst = 1'b1; exp_q.delete(); exp_cnt = 0;
    tick();
    rst = 1'b0;
    chk("unhalt", 64'(halted), 64'd0);
    chk("unhalt_ready", 64'(in_ready), 64'd1);
    cm_ready = 1'b0;
    issue(64'h8000_0100, 32'h0000_0013, 5'd1, 64'd5, 64'd0, 1'b1);
    issue(64'h8000_0104, 32'h0000_0013, 5'd2, 64'd6, 64'd0, 1'b1);
    in_valid = 1'b0;
    chk("pre_rst_cm_valid", 64'(cm_valid), 64'd1);
    rst = 1'b1; exp_q.delete(); exp_cnt = 0;
    tick();
    chk("rst2_cm_valid", 64'(cm_valid), 64'd0);
    chk("rst2_retired", retired_cnt, 64'd0);
    chk("rst2_in_ready", 64'(in_ready), 64'd1);
    chk("rst2_wb_ena", 64'(wb_rd_ena), 64'd0);
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_commit_stage.md
# wb_commit_stage

Parametrised writeback/commit stage between the MEM/WB boundary and the register file. It registers the writeback (rd data/addr/enable) with handshake-based flow control and flush. It pushes every retired instruction into a commit-trace FIFO consumed by the difftest/trace port, and detects the EBREAK trap, drains outstanding trace entries, then halts the core.

## Interface
Parameters:
- XLEN, 64, register/PC width
- ILEN, 32, instruction width
- RADDR_W, 5, register address width
- TRACE_DEPTH, 4, commit FIFO entries (power of two, >=2)
- TRAP_INST, 32'h0010_0073, instruction encoding treated as trap

Ports:
- clk  in  1  clock
- rst  in  1  reset: rst, synchronous, active-high; clock clk
- in_valid  in  1  MEM stage presents an instruction
- in_ready  out  1  stage accepts this cycle
- in_pc  in  XLEN  instruction PC
- in_inst  in  ILEN  instruction word; 0 = bubble
- in_rd_ena / in_rd_addr / in_rd_data  in  1 / RADDR_W / XLEN  writeback request
- in_trap_code  in  XLEN  exit code sampled with a trap instruction
- flush  in  1  kill the in-flight input and clear the WB register
- wb_rd_ena / wb_rd_addr / wb_rd_data  out  1 / RADDR_W / XLEN  registered regfile write port
- cm_valid  out  1  trace entry available
- cm_ready  in  1  trace consumer pops
- cm_pc / cm_inst  out  XLEN / ILEN  retired PC and instruction
- cm_trap / cm_trap_code  out  1 / XLEN  entry is the trap, with its exit code
- retired_cnt  out  64  count of retired (non-bubble) instructions
- halted  out  1  trap retired and trace drained

## Operation
- Accept = in_valid & in_ready.
- in_ready = (state==RUN) & !flush & (!fifo_full | cm_ready).
- On accept with in_inst!=0:
  - WB register loads in_rd_*. wb_rd_ena is forced 0 when in_rd_addr==0.
  - FIFO push {in_pc, in_inst, trap, trap?in_trap_code:0}, with trap = (in_inst==TRAP_INST).
  - retired_cnt increments.
- On accept of a bubble (in_inst==0): wb_rd_ena<=0; no push; no count.
- No accept and no flush: wb_rd_ena<=0. WB data/addr hold. Each write is a single-cycle pulse.
- flush: wb_rd_ena<=0, addr<=0, data<=0. FIFO contents are untouched, because retired entries are never revoked.
- State machine:
  - RUN -> DRAIN on accept of a trap instruction.
  - DRAIN -> HALT when the FIFO is empty.
  - HALT is held until rst.
  - in_ready=0 in DRAIN/HALT. halted=1 only in HALT.
- FIFO pop on cm_valid & cm_ready. Entries are presented in order.

## Timing
- Reset values: all wb_* 0, cm_valid 0, cm_* 0, retired_cnt 0, halted 0, state RUN, FIFO empty.
- WB latency is 1 cycle: accept at edge N, wb_rd_ena high during cycle N+1.
- Trace latency is 1 cycle: a push at edge N gives cm_valid=1 in cycle N+1 when the FIFO was empty. There is no bypass.
- Full FIFO with simultaneous push and pop is legal, and the count is unchanged. in_ready has a combinational path from cm_ready.
- Empty FIFO: a pop request is ignored.
- Pointers wrap modulo TRACE_DEPTH. Count width is $clog2(TRACE_DEPTH)+1.
- flush and in_valid in the same cycle: the input is not accepted, and flush wins.
- A trap accepted with an empty FIFO: DRAIN lasts until that entry pops. halted rises the cycle after the pop edge.
- rst mid-operation clears the FIFO and the state on the next edge, and in-flight entries are discarded.
- retired_cnt wraps at 2^64.

## Structure
- Shared package `wb_commit_pkg`: TRAP_INST default constant, state enum {RUN, DRAIN, HALT}, commit-entry struct {pc, inst, trap, trap_code}.
- Sub-module `sync_fifo`: parametrised width/depth, synchronous-reset FIFO with full/empty/count. It is reused elsewhere.
- The top level holds the WB register, accept logic, FSM, and counter.

## Test plan
- Reset, then stream 3 instrs (pc 0x8000_0000/4/8, rd x5..x7, data 1/2/3) with cm_ready=1:
  - wb_rd_ena pulses on cycles 1-3 with the matching data.
  - cm_pc emits in the same order, one cycle later.
  - retired_cnt=3.
- rd_addr=0 with rd_ena=1, inst 0x0000_0013: wb_rd_ena stays 0, one trace entry is pushed, and retired_cnt increments.
- cm_ready=0 with TRACE_DEPTH=4: after 4 accepts in_ready=0. Raising cm_ready for one cycle gives a simultaneous push and pop, and count stays 4.
- flush together with in_valid (pc 0x8000_0010): no accept, wb outputs 0, FIFO count unchanged.
- Trap inst 0x0010_0073 with in_trap_code=0 behind 2 pending entries, cm_ready=1:
  - in_ready drops the next cycle.
  - The third pop has cm_trap=1, code 0.
  - halted=1 the following cycle and stays until rst.
- rst asserted while the FIFO holds 2 entries: next cycle cm_valid=0, retired_cnt=0, in_ready=1.
